// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM in the low half of the address space, MMIO page
// (cycle counter, byte TX FIFO, GPIO) in the high half. Optional DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           address_dmem,
    input  logic [31:0]           data,
    input  logic                  wren,
    output logic [31:0]           q_dmem,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  fault
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q  [RAM_DEPTH];
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           cycle_q;
    logic [GPIO_WIDTH-1:0] gpio_q;
    logic [31:0]           q_d;

    logic                  is_mmio;
    logic                  oob;
    logic [3:0]            offset;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  mmio_we;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;

    assign is_mmio = address_dmem[31];
    assign offset  = address_dmem[3:0];
    assign ram_idx = address_dmem[ADDR_WIDTH-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = !is_mmio && (|address_dmem[30:ADDR_WIDTH]);
`else
    // Upper RAM address bits alias onto the implemented range.
    logic unused_hi_addr;
    assign unused_hi_addr = ^address_dmem[30:ADDR_WIDTH];
    assign oob = 1'b0;
`endif

    assign ram_we   = wren && !reset && !is_mmio && !oob;
    assign mmio_we  = wren && !reset && is_mmio;
    assign push_req = mmio_we && (offset == 4'd1);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = tx_valid && tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign gpio_out = gpio_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (mmio_we && (offset == 4'd2)) begin
            ovf_d = 1'b0;
        end
    end

    // Load data reflects state before this edge; RAM is write-first.
    always_comb begin
        q_d = '0;
        if (is_mmio) begin
            case (offset)
                4'd0:    q_d = cycle_q;
                4'd1:    q_d = 32'(count_q);
                4'd2:    q_d = {29'b0, ovf_q, fifo_full, fifo_empty};
                4'd3:    q_d = 32'(gpio_q);
                default: q_d = '0;
            endcase
        end else if (!oob) begin
            q_d = wren ? data : mem_q[ram_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem   <= '0;
            cycle_q  <= '0;
            gpio_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            q_dmem   <= q_d;
            cycle_q  <= cycle_q + 32'd1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (mmio_we && (offset == 4'd3)) begin
                gpio_q <= data[GPIO_WIDTH-1:0];
            end
        end
    end

    // Storage arrays carry no reset; RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem_q[ram_idx] <= data;
        end
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= data[7:0];
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic fault_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= oob;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: RAM, cycle counter, TX FIFO, GPIO, bounds and reset.
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] gpio_out;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [7:0]  txq   [$];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    dmem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .gpio_out    (gpio_out),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle; the FIFO model tracks pops and accepted pushes.
    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input bit chk, input logic [31:0] e, input string tag);
        logic popping;
        @(negedge clock);
        address_dmem = a;
        data         = d;
        wren         = we;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        #1;
        popping = tx_valid && tx_ready;
        if (popping) begin
            if (txq.size() != 0) check_val({tag, "_pop"}, 32'(tx_data), 32'(txq.pop_front()));
            else check_val({tag, "_pop_extra"}, 32'(tx_valid), 32'd0);
        end
        if (we && a[31] && (a[3:0] == 4'd1) && !reset && (txq.size() < 8)) begin
            txq.push_back(d[7:0]);
        end
        @(posedge clock);
        #1;
        wren = 1'b0;
        if (chk) check_val(tag_q.pop_front(), q_dmem, exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            tx_ready = 1'b1;
            #1;
            if (!tx_valid) done = 1'b1;
            else if (txq.size() == 0) check_val({tag, "_extra"}, 32'(tx_valid), 32'd0);
            else check_val(tag, 32'(tx_data), 32'(txq.pop_front()));
        end
        tx_ready = 1'b0;
        check_val({tag, "_left"}, 32'(txq.size()), 32'd0);
        check_val({tag, "_valid"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_q", q_dmem, 32'd0);
        check_val("rst_valid", 32'(tx_valid), 32'd0);
        check_val("rst_txdata", 32'(tx_data), 32'd0);
        check_val("rst_gpio", 32'(gpio_out), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);

        // Cycle counter: five idle cycles after reset
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        op(32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'd5, "cycle0");
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd6, "cycle1_wr_ignored");
        op(32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'd7, "cycle2");

        // RAM store/load and write-first
        op(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, "ram_wf1");
        op(32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'h1234_5678, "ram_rd1");
        op(32'h0000_0020, 32'h0000_00A5, 1'b1, 1'b1, 32'h0000_00A5, "ram_wf2");
        op(32'h0000_0020, 32'd0, 1'b0, 1'b1, 32'h0000_00A5, "ram_rd2");
        op(32'h0000_0010, 32'd0, 1'b0, 1'b1, 32'h1234_5678, "ram_rd3");

        // Fill past capacity with the consumer stalled
        for (int i = 0; i < 9; i++) begin
            op(32'h8000_0001, 32'h41 + i, 1'b1, 1'b1, (i < 8) ? i : 8, "occ_push");
        end
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd6, "status_ovf_full");
        op(32'h8000_0001, 32'd0, 1'b0, 1'b1, 32'd8, "occ_full");
        check_val("head_full", 32'(tx_data), 32'h41);
        drain("drain1");
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd5, "status_ovf_empty");

        // Clear overflow, refill, push-while-full with a simultaneous pop
        op(32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, "status_clr");
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd1, "status_cleared");
        for (int i = 0; i < 8; i++) begin
            op(32'h8000_0001, 32'h61 + i, 1'b1, 1'b1, i, "occ_push2");
        end
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd2, "status_full");
        tx_ready = 1'b1;
        op(32'h8000_0001, 32'h5A, 1'b1, 1'b1, 32'd8, "push_full_pop");
        tx_ready = 1'b0;
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd2, "status_no_ovf");
        op(32'h8000_0001, 32'd0, 1'b0, 1'b1, 32'd8, "occ_after_swap");
        drain("drain2");
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd1, "status_empty");

        // GPIO and unmapped offsets
        op(32'h8000_0003, 32'h0001_BEEF, 1'b1, 1'b0, 32'd0, "gpio_wr");
        check_val("gpio_out", 32'(gpio_out), 32'h0000_BEEF);
        op(32'h8000_0003, 32'd0, 1'b0, 1'b1, 32'h0000_BEEF, "gpio_rd");
        op(32'h8000_0FF3, 32'd0, 1'b0, 1'b1, 32'h0000_BEEF, "gpio_rd_alias");
        op(32'h8000_0007, 32'h1234, 1'b1, 1'b1, 32'd0, "unmapped");
        check_val("gpio_kept", 32'(gpio_out), 32'h0000_BEEF);

        // Bounds / aliasing
        op(32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D, "ram0_wr");
        check_val("fault_inrange", 32'(fault), 32'd0);
        op(32'h0000_1000, 32'h1111_1111, 1'b1, 1'b1, OOB_EN ? 32'd0 : 32'h1111_1111, "oob_st");
        check_val("fault_pulse", 32'(fault), OOB_EN ? 32'd1 : 32'd0);
        op(32'h0000_0000, 32'd0, 1'b0, 1'b1, OOB_EN ? 32'hCAFE_F00D : 32'h1111_1111, "ram0_rd");
        check_val("fault_end", 32'(fault), 32'd0);

        // Reset mid-transmit, with a store presented during reset
        for (int i = 0; i < 3; i++) begin
            op(32'h8000_0001, 32'h71 + i, 1'b1, 1'b1, i, "occ_push3");
        end
        @(negedge clock);
        reset        = 1'b1;
        tx_ready     = 1'b1;
        wren         = 1'b1;
        address_dmem = 32'h0000_0000;
        data         = 32'hDEAD_BEEF;
        #1;
        check_val("pre_rst_valid", 32'(tx_valid), 32'd1);
        @(posedge clock);
        #1;
        check_val("rst_mid_valid", 32'(tx_valid), 32'd0);
        check_val("rst_mid_txdata", 32'(tx_data), 32'd0);
        check_val("rst_mid_q", q_dmem, 32'd0);
        check_val("rst_mid_gpio", 32'(gpio_out), 32'd0);
        txq.delete();
        wren     = 1'b0;
        tx_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        op(32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'd1, "cycle_after_rst");
        op(32'h8000_0002, 32'd0, 1'b0, 1'b1, 32'd1, "status_after_rst");
        op(32'h0000_0000, 32'd0, 1'b0, 1'b1, OOB_EN ? 32'hCAFE_F00D : 32'h1111_1111, "ram_kept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
